// File: rtl/ctrl_unit_pipe.sv
// Registered ID-stage control unit: decodes {s, mode, op_code} into a one-entry held control word.
// Optional multi-cycle MUL sequencing when CTRL_UNIT_MUL_EN is defined.
//
// state    | meaning
// EMPTY    | no control word held, ready for input
// FULL     | control word held and presented with out_valid
// MUL_BUSY | MUL accepted, down-counter running before the word is presented
module ctrl_unit_pipe #(
  parameter int EXE_CMD_W  = 4,
  parameter int DEST_W     = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_s,
  input  logic [1:0]           in_mode,
  input  logic [3:0]           in_op_code,
  input  logic [DEST_W-1:0]    in_dest,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXE_CMD_W-1:0] out_exe_cmd,
  output logic                 out_mem_r_en,
  output logic                 out_mem_w_en,
  output logic                 out_wb_en,
  output logic                 out_b,
  output logic                 out_s,
  output logic                 out_two_src,
  output logic [DEST_W-1:0]    out_dest,
  output logic                 busy
);

  typedef enum logic [1:0] {EMPTY, FULL, MUL_BUSY} state_t;

  localparam int CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam int CNT_LOAD = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, load;

  logic [3:0] dec_exe;
  logic       dec_mem_r, dec_mem_w, dec_wb, dec_b, dec_two_src, dec_mul;

  logic [EXE_CMD_W-1:0] exe_q;
  logic                 mem_r_q, mem_w_q, wb_q, b_q, s_q, two_src_q;
  logic [DEST_W-1:0]    dest_q;

  always_comb begin
    dec_exe     = 4'b0000;
    dec_mem_r   = 1'b0;
    dec_mem_w   = 1'b0;
    dec_wb      = 1'b0;
    dec_b       = 1'b0;
    dec_two_src = 1'b1;
    dec_mul     = 1'b0;
    case (in_mode)
      2'b00: begin
        case (in_op_code)
          4'b1101: begin dec_exe = 4'b0001; dec_wb = 1'b1; dec_two_src = 1'b0; end
          4'b1111: begin dec_exe = 4'b1001; dec_wb = 1'b1; dec_two_src = 1'b0; end
          4'b0100: begin dec_exe = 4'b0010; dec_wb = 1'b1; end
          4'b0101: begin dec_exe = 4'b0011; dec_wb = 1'b1; end
          4'b0010: begin dec_exe = 4'b0100; dec_wb = 1'b1; end
          4'b0110: begin dec_exe = 4'b0101; dec_wb = 1'b1; end
          4'b0000: begin dec_exe = 4'b0110; dec_wb = 1'b1; end
          4'b1100: begin dec_exe = 4'b0111; dec_wb = 1'b1; end
          4'b0001: begin dec_exe = 4'b1000; dec_wb = 1'b1; end
          4'b1010: dec_exe = 4'b1100;
          4'b1000: dec_exe = 4'b1110;
`ifdef CTRL_UNIT_MUL_EN
          4'b1001: begin dec_exe = 4'b1011; dec_wb = 1'b1; dec_mul = 1'b1; end
`endif
          default: ;
        endcase
      end
      2'b01: begin
        dec_exe = 4'b1010;
        if (in_s) begin
          dec_mem_r = 1'b1;
          dec_wb    = 1'b1;
        end else begin
          dec_mem_w = 1'b1;
        end
      end
      2'b10: begin
        dec_b       = 1'b1;
        dec_two_src = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready = ~rst & ((state_q == EMPTY) | ((state_q == FULL) & out_ready));
  assign accept   = in_valid & in_ready;
  assign load     = accept & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY, FULL: begin
        if (accept) begin
          // a one-cycle MUL is indistinguishable from a normal op
          if (dec_mul && (MUL_CYCLES > 1)) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_W'(CNT_LOAD);
          end else begin
            state_d = FULL;
          end
        end else if ((state_q == FULL) && out_ready) begin
          state_d = EMPTY;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) state_d = FULL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      exe_q     <= '0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      wb_q      <= 1'b0;
      b_q       <= 1'b0;
      s_q       <= 1'b0;
      two_src_q <= 1'b0;
      dest_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        exe_q     <= EXE_CMD_W'(dec_exe);
        mem_r_q   <= dec_mem_r;
        mem_w_q   <= dec_mem_w;
        wb_q      <= dec_wb;
        b_q       <= dec_b;
        s_q       <= in_s;
        two_src_q <= dec_two_src;
        dest_q    <= in_dest;
      end
    end
  end

  // enables are masked outside FULL so EMPTY/MUL_BUSY present a bubble
  assign out_valid    = (state_q == FULL);
  assign out_exe_cmd  = exe_q;
  assign out_mem_r_en = mem_r_q & out_valid;
  assign out_mem_w_en = mem_w_q & out_valid;
  assign out_wb_en    = wb_q & out_valid;
  assign out_b        = b_q & out_valid;
  assign out_s        = s_q;
  assign out_two_src  = two_src_q;
  assign out_dest     = dest_q;

`ifdef CTRL_UNIT_MUL_EN
  assign busy = (state_q == MUL_BUSY);
`else
  assign busy = 1'b0;
`endif

endmodule
